deca_i2c_target_model: RTL and testbench

//  Synthesizable I2C target model on the RH_TEMP_I2C bus of the Deca sim top level, downstream of the SoC master.

---
 rtl/deca_i2c_pkg.sv | 20 ++
 rtl/deca_i2c_target_model_if.sv | 9 +
 rtl/deca_i2c_line_filter.sv | 48 ++++
 rtl/deca_i2c_target_model.sv | 237 +++++++++++++++++++++++
 tb/tb_deca_i2c_target_model.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/deca_i2c_pkg.sv
// Shared types for the Deca RH_TEMP I2C target model: FSM states and bit-counter landmarks.
package deca_i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    AACK,
    PTR,
    WR,
    RD,
    MACK,
    IGNORE
  } i2c_state_e;

  localparam logic       I2C_RW_READ = 1'b1;
  // Bit counter values: 8 = byte complete, 9 = inside the ACK clock.
  localparam logic [3:0] BIT_BYTE    = 4'd8;
  localparam logic [3:0] BIT_ACK     = 4'd9;

endpackage

// File: rtl/deca_i2c_target_model_if.sv
// Resolved open-drain I2C lines seen by the target, plus the target's SDA pull-down request.
interface deca_i2c_target_model_if;
  logic scl;
  logic sda;
  logic sda_oe;

  modport slave  (input scl, input sda, output sda_oe);
  modport master (output scl, output sda, input sda_oe);
endinterface

// File: rtl/deca_i2c_line_filter.sv
// Two-flop synchroniser followed by a FILT-cycle stability filter; emits level and edge pulses.
module deca_i2c_line_filter #(
  parameter int FILT = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  localparam int CW = $clog2(FILT + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          rise_q;
  logic          fall_q;

  // Idle bus level is high, so the filter starts high to avoid a spurious edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], i_line};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILT - 1)) begin
        level_q <= sync_q[1];
        rise_q  <= sync_q[1];
        fall_q  <= ~sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;
endmodule

// File: rtl/deca_i2c_target_model.sv
// I2C target with an auto-incrementing 8-bit register file for the Deca RH_TEMP bus.
// Optional DRDY pin model enabled by defining DECA_I2C_TARGET_DRDY_EN.
module deca_i2c_target_model
  import deca_i2c_pkg::*;
#(
  parameter logic [6:0] ADDR        = 7'h40,
  parameter int         REG_DEPTH   = 16,
  parameter int         FILT        = 3,
  parameter int         CONV_CYCLES = 1000
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  deca_i2c_target_model_if.slave       bus,
  output logic                         o_busy,
  output logic                         o_wr_stb,
  output logic [$clog2(REG_DEPTH)-1:0] o_wr_addr,
  output logic [7:0]                   o_wr_data,
  output logic                         o_drdy_n,
  output i2c_state_e                   o_dbg_state
);
  localparam int PW = $clog2(REG_DEPTH);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  deca_i2c_line_filter #(.FILT(FILT)) u_scl_filt (
    .i_clk(i_clk), .i_rst(i_rst), .i_line(bus.scl),
    .o_level(scl_lvl), .o_rise(scl_rise), .o_fall(scl_fall)
  );
  deca_i2c_line_filter #(.FILT(FILT)) u_sda_filt (
    .i_clk(i_clk), .i_rst(i_rst), .i_line(bus.sda),
    .o_level(sda_lvl), .o_rise(sda_rise), .o_fall(sda_fall)
  );

  i2c_state_e    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    tx_q, tx_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          oe_q, oe_d;
  logic          busy_q, busy_d;
  logic          rw_q, rw_d;
  logic          wr_en;
  logic          wr_stb_q;
  logic [PW-1:0] wr_addr_q;
  logic [7:0]    wr_data_q;
  logic [7:0]    regs_q [REG_DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      ptr_q     <= '0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      rw_q      <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < REG_DEPTH; i++) regs_q[i] <= 8'(8'hA0 + i);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ptr_q    <= ptr_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      rw_q     <= rw_d;
      wr_stb_q <= wr_en;
      if (wr_en) begin
        regs_q[ptr_q] <= shift_d;
        wr_addr_q     <= ptr_q;
        wr_data_q     <= shift_d;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    ptr_d   = ptr_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    rw_d    = rw_q;
    wr_en   = 1'b0;

    // Receive bits commit on the 8th rise so a STOP arriving afterwards cannot lose the write.
    if (scl_rise) begin
      case (state_q)
        deca_i2c_pkg::ADDR, PTR, WR: begin
          if (cnt_q < BIT_BYTE) begin
            shift_d = {shift_q[6:0], sda_lvl};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7 && state_q == PTR) ptr_d = shift_d[PW-1:0];
            if (cnt_q == 4'd7 && state_q == WR) begin
              wr_en = 1'b1;
              ptr_d = ptr_q + 1'b1;
            end
          end
        end
        MACK: begin
          if (cnt_q == BIT_BYTE) begin
            if (!sda_lvl) begin
              ptr_d = ptr_q + 1'b1;
              cnt_d = BIT_ACK;
            end else begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end

    if (scl_fall) begin
      case (state_q)
        deca_i2c_pkg::ADDR: begin
          if (cnt_q == BIT_BYTE) begin
            if (shift_q[7:1] == ADDR) begin
              state_d = AACK;
              oe_d    = 1'b1;
              busy_d  = 1'b1;
              rw_d    = shift_q[0];
            end else begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        AACK: begin
          if (rw_q == I2C_RW_READ) begin
            state_d = RD;
            tx_d    = regs_q[ptr_q];
            oe_d    = ~regs_q[ptr_q][7];
            cnt_d   = 4'd1;
          end else begin
            state_d = PTR;
            oe_d    = 1'b0;
            cnt_d   = '0;
          end
        end
        PTR, WR: begin
          if (cnt_q == BIT_BYTE) begin
            oe_d  = 1'b1;
            cnt_d = BIT_ACK;
          end else if (cnt_q == BIT_ACK) begin
            oe_d    = 1'b0;
            cnt_d   = '0;
            state_d = WR;
          end
        end
        RD: begin
          if (cnt_q == BIT_BYTE) begin
            oe_d    = 1'b0;
            state_d = MACK;
          end else begin
            tx_d  = {tx_q[6:0], 1'b0};
            oe_d  = ~tx_d[7];
            cnt_d = cnt_q + 4'd1;
          end
        end
        MACK: begin
          if (cnt_q == BIT_ACK) begin
            state_d = RD;
            tx_d    = regs_q[ptr_q];
            oe_d    = ~regs_q[ptr_q][7];
            cnt_d   = 4'd1;
          end
        end
        default: ;
      endcase
    end

    // START/STOP override everything else; a partial byte simply never commits.
    if (sda_fall && scl_lvl) begin
      state_d = deca_i2c_pkg::ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else if (sda_rise && scl_lvl) begin
      state_d = IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end
  end

  // o_wr_stb is a valid-only pulse (no ready): o_wr_addr/o_wr_data are valid while it is high and hold after.
  assign bus.sda_oe  = oe_q;
  assign o_busy      = busy_q;
  assign o_wr_stb    = wr_stb_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_dbg_state = state_q;

`ifdef DECA_I2C_TARGET_DRDY_EN
  localparam int CCW = $clog2(CONV_CYCLES + 1);

  logic           rd_done;
  logic [CCW-1:0] conv_q;
  logic           conv_run_q;
  logic           drdy_n_q;

  assign rd_done = scl_rise && (state_q == MACK) && (cnt_q == BIT_BYTE) && (ptr_q == PW'(1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      conv_q     <= '0;
      conv_run_q <= 1'b0;
      drdy_n_q   <= 1'b1;
    end else if (wr_en && ptr_q == '0) begin
      conv_q     <= CCW'(CONV_CYCLES);
      conv_run_q <= 1'b1;
      drdy_n_q   <= 1'b1;
    end else begin
      if (rd_done) drdy_n_q <= 1'b1;
      if (conv_run_q) begin
        if (conv_q == CCW'(1)) begin
          drdy_n_q   <= 1'b0;
          conv_run_q <= 1'b0;
        end else begin
          conv_q <= conv_q - 1'b1;
        end
      end
    end
  end

  assign o_drdy_n = drdy_n_q;
`else
  assign o_drdy_n = 1'b1;
`endif
endmodule

// File: tb/tb_deca_i2c_target_model.sv
// Bench for deca_i2c_target_model: bit-banged I2C master, strobe scoreboard, per-scenario tasks.
`timescale 1ns/1ps
module tb_deca_i2c_target_model;
  import deca_i2c_pkg::*;

  localparam int PW   = 4;
  localparam int Q    = 10;
  localparam int CONV = 100;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  logic       m_scl_oe = 1'b0;
  logic       m_sda_oe = 1'b0;
  logic       busy, wr_stb, drdy_n;
  logic [PW-1:0] wr_addr;
  logic [7:0] wr_data;
  i2c_state_e dbg_state;

  int errors = 0;
  int checks = 0;
  int stb_cnt = 0;
  int cyc = 0;
  int last_stb_cyc = 0;
  int drdy_fall_cyc = -1;
  logic oe_seen = 1'b0;
  logic busy_seen = 1'b0;
  logic drdy_prev = 1'b1;
  logic [PW+7:0] exp_q[$];

  deca_i2c_target_model_if bus();
  assign bus.scl = ~m_scl_oe;
  assign bus.sda = ~(m_sda_oe | bus.sda_oe);

  deca_i2c_target_model #(
    .ADDR(7'h40), .REG_DEPTH(16), .FILT(3), .CONV_CYCLES(CONV)
  ) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus),
    .o_busy(busy), .o_wr_stb(wr_stb), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_drdy_n(drdy_n), .o_dbg_state(dbg_state)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: every strobe pops one expected {addr,data}
  always @(negedge clk) begin
    if (bus.sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (drdy_prev && !drdy_n) drdy_fall_cyc = cyc;
    drdy_prev = drdy_n;
    if (wr_stb) begin
      logic [PW+7:0] e;
      stb_cnt++;
      last_stb_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_strobe unexpected: got addr=%0h data=%02h, required no strobe", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          errors++;
          $display("FAIL wr_strobe: got addr=%0h data=%02h, required addr=%0h data=%02h",
                   wr_addr, wr_data, e[PW+7:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic wait_q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic clk_bit(input logic b, output logic s);
    m_sda_oe = ~b;
    wait_q();
    m_scl_oe = 1'b0;
    wait_q();
    @(negedge clk) s = bus.sda;
    wait_q();
    m_scl_oe = 1'b1;
    wait_q();
  endtask

  task automatic i2c_start();
    m_sda_oe = 1'b0;
    wait_q();
    m_scl_oe = 1'b0;
    wait_q();
    m_sda_oe = 1'b1;
    wait_q();
    m_scl_oe = 1'b1;
    wait_q();
  endtask

  task automatic i2c_stop();
    m_sda_oe = 1'b1;
    wait_q();
    m_scl_oe = 1'b0;
    wait_q();
    m_sda_oe = 1'b0;
    wait_q();
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(~mack, s);
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 7;
    if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b required 0", bus.sda_oe); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (wr_stb !== 1'b0) begin errors++; $display("FAIL reset_wr_stb: got %b required 0", wr_stb); end
    if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr: got %0h required 0", wr_addr); end
    if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %02h required 00", wr_data); end
    if (drdy_n !== 1'b1) begin errors++; $display("FAIL reset_drdy_n: got %b required 1", drdy_n); end
    if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d required IDLE", dbg_state); end
    @(posedge clk) #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_write();
    logic [3:0] a;
    logic busy_mid;
    int s0 = stb_cnt;
    exp_q.push_back({4'd5, 8'h11});
    exp_q.push_back({4'd6, 8'h22});
    i2c_start();
    write_byte(8'h80, a[3]);
    @(negedge clk) busy_mid = busy;
    write_byte(8'h05, a[2]);
    write_byte(8'h11, a[1]);
    write_byte(8'h22, a[0]);
    i2c_stop();
    @(negedge clk);
    checks += 5;
    if (a !== 4'b1111) begin errors++; $display("FAIL write_acks: got %b required 1111", a); end
    if (busy_mid !== 1'b1) begin errors++; $display("FAIL write_busy_mid: got %b required 1", busy_mid); end
    if (stb_cnt - s0 != 2) begin errors++; $display("FAIL write_strobe_count: got %0d required 2", stb_cnt - s0); end
    if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop: got %b required 0", busy); end
    if (dbg_state !== IDLE) begin errors++; $display("FAIL write_state_after_stop: got %0d required IDLE", dbg_state); end
  endtask

  task automatic test_wrap_read();
    logic [4:0] a;
    logic [2:0] b;
    logic [7:0] d0, d1, d2, d3;
    exp_q.push_back({4'd15, 8'hAA});
    exp_q.push_back({4'd0, 8'hBB});
    i2c_start();
    write_byte(8'h80, a[4]);
    write_byte(8'h0F, a[3]);
    write_byte(8'hAA, a[2]);
    write_byte(8'hBB, a[1]);
    i2c_start();
    write_byte(8'h81, a[0]);
    read_byte(1'b1, d0);
    read_byte(1'b0, d1);
    i2c_stop();
    i2c_start();
    write_byte(8'h80, b[2]);
    write_byte(8'h0F, b[1]);
    i2c_start();
    write_byte(8'h81, b[0]);
    read_byte(1'b1, d2);
    read_byte(1'b0, d3);
    i2c_stop();
    @(negedge clk);
    checks += 7;
    if (a !== 5'b11111) begin errors++; $display("FAIL wrap_acks: got %b required 11111", a); end
    if (d0 !== 8'hA1) begin errors++; $display("FAIL wrap_read_reg1: got %02h required a1", d0); end
    if (d1 !== 8'hA2) begin errors++; $display("FAIL wrap_read_reg2: got %02h required a2", d1); end
    if (b !== 3'b111) begin errors++; $display("FAIL wrap_readback_acks: got %b required 111", b); end
    if (d2 !== 8'hAA) begin errors++; $display("FAIL wrap_read_reg15: got %02h required aa", d2); end
    if (d3 !== 8'hBB) begin errors++; $display("FAIL wrap_read_reg0: got %02h required bb", d3); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_pending_strobes: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_addr_mismatch();
    logic [2:0] a;
    int s0 = stb_cnt;
    oe_seen = 1'b0;
    busy_seen = 1'b0;
    i2c_start();
    write_byte(8'h84, a[2]);
    write_byte(8'h00, a[1]);
    write_byte(8'h55, a[0]);
    i2c_stop();
    @(negedge clk);
    checks += 5;
    if (a !== 3'b000) begin errors++; $display("FAIL mismatch_acks: got %b required 000", a); end
    if (oe_seen !== 1'b0) begin errors++; $display("FAIL mismatch_sda_driven: got %b required 0", oe_seen); end
    if (busy_seen !== 1'b0) begin errors++; $display("FAIL mismatch_busy: got %b required 0", busy_seen); end
    if (stb_cnt != s0) begin errors++; $display("FAIL mismatch_strobes: got %0d required 0", stb_cnt - s0); end
    if (dbg_state !== IDLE) begin errors++; $display("FAIL mismatch_state: got %0d required IDLE", dbg_state); end
  endtask

  task automatic test_stop_midbyte();
    logic [2:0] a;
    logic s;
    logic [7:0] d;
    int s0 = stb_cnt;
    i2c_start();
    write_byte(8'h80, a[2]);
    write_byte(8'h07, a[1]);
    clk_bit(1'b1, s);
    clk_bit(1'b0, s);
    clk_bit(1'b1, s);
    clk_bit(1'b0, s);
    i2c_stop();
    @(negedge clk);
    checks += 2;
    if (stb_cnt != s0) begin errors++; $display("FAIL midbyte_strobe: got %0d required 0", stb_cnt - s0); end
    if (dbg_state !== IDLE) begin errors++; $display("FAIL midbyte_state: got %0d required IDLE", dbg_state); end
    i2c_start();
    write_byte(8'h81, a[0]);
    read_byte(1'b0, d);
    i2c_stop();
    @(negedge clk);
    checks += 2;
    if (a !== 3'b111) begin errors++; $display("FAIL midbyte_acks: got %b required 111", a); end
    if (d !== 8'hA7) begin errors++; $display("FAIL midbyte_read_old_ptr: got %02h required a7", d); end
  endtask

  task automatic test_reset_in_read();
    logic a0, s;
    logic [2:0] b;
    logic [7:0] d0, d1;
    i2c_start();
    write_byte(8'h81, a0);
    clk_bit(1'b1, s);
    @(negedge clk);
    checks += 3;
    if (a0 !== 1'b1) begin errors++; $display("FAIL rst_read_ack: got %b required 1", a0); end
    if (s !== 1'b1) begin errors++; $display("FAIL rst_read_bit7: got %b required 1", s); end
    if (bus.sda_oe !== 1'b1) begin errors++; $display("FAIL rst_read_driving: got %b required 1", bus.sda_oe); end
    rst = 1'b1;
    #1;
    checks += 3;
    if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL rst_async_sda_oe: got %b required 0", bus.sda_oe); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b required 0", busy); end
    if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_async_state: got %0d required IDLE", dbg_state); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_sda_oe = 1'b0;
    wait_q();
    i2c_stop();
    i2c_start();
    write_byte(8'h80, b[2]);
    write_byte(8'h0F, b[1]);
    i2c_start();
    write_byte(8'h81, b[0]);
    read_byte(1'b1, d0);
    read_byte(1'b0, d1);
    i2c_stop();
    @(negedge clk);
    checks += 3;
    if (b !== 3'b111) begin errors++; $display("FAIL rst_reinit_acks: got %b required 111", b); end
    if (d0 !== 8'hAF) begin errors++; $display("FAIL rst_reinit_reg15: got %02h required af", d0); end
    if (d1 !== 8'hA0) begin errors++; $display("FAIL rst_reinit_reg0: got %02h required a0", d1); end
  endtask

  task automatic test_drdy();
`ifdef DECA_I2C_TARGET_DRDY_EN
    logic [5:0] a;
    logic [7:0] d;
    exp_q.push_back({4'd0, 8'h33});
    drdy_fall_cyc = -1;
    i2c_start();
    write_byte(8'h80, a[5]);
    write_byte(8'h00, a[4]);
    write_byte(8'h33, a[3]);
    i2c_stop();
    repeat (150) @(posedge clk);
    @(negedge clk);
    checks += 3;
    if (a[5:3] !== 3'b111) begin errors++; $display("FAIL drdy_write_acks: got %b required 111", a[5:3]); end
    if (drdy_n !== 1'b0) begin errors++; $display("FAIL drdy_low: got %b required 0", drdy_n); end
    if (drdy_fall_cyc - last_stb_cyc != CONV) begin
      errors++;
      $display("FAIL drdy_delay: got %0d cycles required %0d", drdy_fall_cyc - last_stb_cyc, CONV);
    end
    i2c_start();
    write_byte(8'h80, a[2]);
    write_byte(8'h01, a[1]);
    i2c_start();
    write_byte(8'h81, a[0]);
    read_byte(1'b0, d);
    i2c_stop();
    @(negedge clk);
    checks += 2;
    if (d !== 8'hA1) begin errors++; $display("FAIL drdy_read_reg1: got %02h required a1", d); end
    if (drdy_n !== 1'b1) begin errors++; $display("FAIL drdy_cleared: got %b required 1", drdy_n); end
`else
    @(negedge clk);
    checks++;
    if (drdy_n !== 1'b1) begin errors++; $display("FAIL drdy_tied_high: got %b required 1", drdy_n); end
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrap_read();
    test_addr_mismatch();
    test_stop_midbyte();
    test_reset_in_read();
    test_drdy();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL final_pending_strobes: got %0d required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
